reg_file32: RTL and testbench
=============================

# reg_file32

Two-read, one-write 32 x 32-bit general register file for the single-cycle CPU. It sits directly upstream of the ALU: read port A drives the ALU `Adat` operand, and read port B drives `Bdat`, either directly or through the immediate mux. Writeback from the ALU result or the data-memory load path returns on the write port at the clock edge that ends the instruction. A third read-only debug port lets the board display inspect any register without disturbing execution.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ra_addr  input  ADDR_W  read port A address (rs).
- rb_addr  input  ADDR_W  read port B address (rt).
- ra_data  output  DATA_W  read port A data, to ALU `Adat`.
- rb_data  output  DATA_W  read port B data, to ALU `Bdat` / store data.
- we  input  1  write enable.
- w_addr  input  ADDR_W  write address (rd/rt from the destination mux).
- w_data  input  DATA_W  write data (ALU Result or load data).
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data.
- wr_count  output  16  number of committed writes since reset.

## Operation
- Storage: registers 1..31, each DATA_W bits. Register 0 has no storage and always reads 0.
- Reads: all three ports are combinational from address to data. Address 0 returns 32'h0.
- Write: on the rising clk edge with we=1 and w_addr!=0, the register at w_addr takes w_data.
- Writes to address 0 are discarded. They do not increment wr_count.
- wr_count increments by 1 on each committed write. It wraps from 16'hFFFF to 16'h0000.
- Reset: asserting rst_n low immediately clears registers 1..31 and wr_count to 0.
  - While reset is held, ra_data, rb_data and dbg_data all read 0.
  - Writes are ignored while rst_n is low.
- Reset mid-write: if rst_n falls in the same cycle as we=1, reset wins and the register reads 0.
- Reset release: the first edge with rst_n high behaves as a normal cycle.
- Simultaneous events:
  - ra_addr and rb_addr may be equal; both ports return the same value.
  - dbg_addr may equal w_addr; the debug port follows the same bypass rule as ports A and B.
- No state machine beyond per-register storage and the write counter.

## Timing
- Read latency: 0 cycles, combinational. Read paths must settle within the single-cycle budget ahead of the 32-bit ALU adder.
- Write latency: 1 edge. Data written at edge N is visible on the read ports after edge N.
- Same-cycle read of the register being written (we=1, w_addr==r_addr!=0): the result depends on build configuration; see Configuration.
- Reset values: ra_data=0, rb_data=0, dbg_data=0, wr_count=0.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read whose address matches w_addr while we=1 and w_addr!=0 returns w_data in the same cycle (write-through forwarding). This applies to ra, rb and dbg.
- `REGFILE_BYPASS_EN` undefined: reads always return stored contents, i.e. the old value until the edge.
- The single-cycle core builds without the macro. The future pipelined core defines it.

## Structure
- Shared package `cpu_pkg` holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - Named register constants REG_SP=5'd29 and REG_RA=5'd31, used by control.
- One sub-module, `rf_read_port`, instantiated three times:
  - Inputs: address, storage array, write-bypass inputs.
  - Function: zero-register forcing, bypass compare and the 32:1 mux.
- The top level holds storage, write decode and wr_count.

## Test plan
- Reset, then read all 32 addresses on ra, rb and dbg -> every read is 32'h0 and wr_count is 0.
- Write 32'hDEADBEEF to r5, then read ra=5 and rb=5 on the next cycle -> both return 32'hDEADBEEF and wr_count is 1.
- Write 32'h12345678 to r0, then read ra=0 -> returns 32'h0 and wr_count is unchanged.
- r7 holds 32'h1; in the same cycle write 32'h2 to r7 with ra=7. Read ra before the edge -> 32'h1 without the macro, 32'h2 with `REGFILE_BYPASS_EN`. After the edge, both builds return 32'h2.
- Fill r1..r31 with 32'h100+i, then pulse rst_n low between edges -> all reads return 0 immediately, and a later read of r9 stays 0 until it is rewritten.
- Perform 65537 writes to r1 -> wr_count reads 16'h0001, confirming wrap-around.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-wide constants and types: register-file geometry, named
// architectural registers, and the write-request bundle that the register
// file hands to each of its read ports for write-through forwarding.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_DEPTH  = 2 ** REG_ADDR_W;
    localparam int WR_COUNT_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef logic [WR_COUNT_W-1:0] wr_count_t;

    // Full architectural view of the register file, index 0 included.
    typedef reg_data_t [REG_DEPTH-1:0] reg_array_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

    // A qualified write: en is only high for a write that will commit.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

endpackage

// File: rtl/reg_file32_if.sv
// ---------------------------------------------------------------------------
// reg_file32_if
// Bus between the CPU datapath and the register file.
//   ra_addr/ra_data   : read port A (rs -> ALU Adat)
//   rb_addr/rb_data   : read port B (rt -> ALU Bdat / store data)
//   we/w_addr/w_data  : write port (writeback)
//   dbg_addr/dbg_data : debug read port for the board display
//   wr_count          : committed writes since reset
// Modports: master = datapath side, slave = register file side.
// ---------------------------------------------------------------------------
interface reg_file32_if;
    import cpu_pkg::*;

    reg_addr_t ra_addr;
    reg_addr_t rb_addr;
    reg_data_t ra_data;
    reg_data_t rb_data;
    logic      we;
    reg_addr_t w_addr;
    reg_data_t w_data;
    reg_addr_t dbg_addr;
    reg_data_t dbg_data;
    wr_count_t wr_count;

    modport master (
        output ra_addr, rb_addr, we, w_addr, w_data, dbg_addr,
        input  ra_data, rb_data, dbg_data, wr_count
    );

    modport slave (
        input  ra_addr, rb_addr, we, w_addr, w_data, dbg_addr,
        output ra_data, rb_data, dbg_data, wr_count
    );

endinterface

// File: rtl/reg_file32_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file.
//   addr : register address
//   regs : full register array (entry 0 is ignored, r0 is forced to 0)
//   wr   : qualified write request, used for write-through forwarding
//   data : read data
// Build option: REGFILE_BYPASS_EN enables same-cycle forwarding of w_data
// when addr matches a committing write.
// ---------------------------------------------------------------------------
module rf_read_port
    import cpu_pkg::*;
(
    input  reg_addr_t  addr,
    input  reg_array_t regs,
    input  wr_req_t    wr,
    output reg_data_t  data
);

    always_comb begin
        // NOTE: data gets a value before any condition so no path through
        // this block leaves it unassigned; otherwise a latch is inferred.
        data = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr.en && (wr.addr == addr)) begin
            data = wr.data;
        end
`endif
        // r0 wins over everything, including a forwarded value.
        if (addr == REG_ZERO) begin
            data = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Forwarding inputs are intentionally unused without the bypass.
    logic unused_wr;
    assign unused_wr = ^wr;
`endif

endmodule

// File: rtl/reg_file32.sv
// ---------------------------------------------------------------------------
// reg_file32
// Two-read, one-write 32 x 32-bit register file with a read-only debug port.
//   clk   : system clock, state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears r1..r31 and wr_count
//   bus   : reg_file32_if.slave (read ports A/B, write port, debug port,
//           wr_count)
// r0 has no storage and always reads 0; writes to r0 are dropped and are not
// counted. Reads are combinational. Build option REGFILE_BYPASS_EN forwards
// a committing write to any read port addressing the same register.
// ---------------------------------------------------------------------------
module reg_file32
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    reg_file32_if.slave  bus
);

    // Storage exists only for r1..r31.
    reg_data_t [REG_DEPTH-1:1] mem_q;
    reg_array_t                regs_view;
    wr_count_t                 wr_count_q;
    wr_req_t                   wr;

    // A write commits only outside reset and never to r0. Qualifying with
    // rst_n here also keeps the bypass from forwarding while reset is held.
    assign wr = '{
        en:   bus.we && rst_n && (bus.w_addr != REG_ZERO),
        addr: bus.w_addr,
        data: bus.w_data
    };

    // NOTE: the register array sits on the async reset because the CPU
    // relies on r1..r31 reading 0 right after reset; plain RAM-style arrays
    // normally stay unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            for (int i = 1; i < REG_DEPTH; i++) begin
                // NOTE: state is updated with non-blocking assignments so
                // every flop samples pre-edge values regardless of order.
                if (wr.en && (wr.addr == reg_addr_t'(i))) begin
                    mem_q[i] <= wr.data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else if (wr.en) begin
            wr_count_q <= wr_count_q + 1'b1;   // wraps at 16'hFFFF
        end
    end

    assign regs_view    = {mem_q, reg_data_t'(0)};
    assign bus.wr_count = wr_count_q;

    rf_read_port u_port_a (
        .addr (bus.ra_addr),
        .regs (regs_view),
        .wr   (wr),
        .data (bus.ra_data)
    );

    rf_read_port u_port_b (
        .addr (bus.rb_addr),
        .regs (regs_view),
        .wr   (wr),
        .data (bus.rb_data)
    );

    rf_read_port u_port_dbg (
        .addr (bus.dbg_addr),
        .regs (regs_view),
        .wr   (wr),
        .data (bus.dbg_data)
    );

endmodule

// File: tb/tb_reg_file32.sv
// ---------------------------------------------------------------------------
// tb_reg_file32
// Self-checking bench for reg_file32. A behavioural model (array + counter)
// predicts every read port and wr_count; a compare process checks them on
// each falling edge, and directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_reg_file32;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    logic cmp_en;

    int n_checks;
    int n_pass;

    reg_file32_if bus ();

    reg_file32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [32];
    logic [15:0] m_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
            m_count <= 16'h0;
        end else if (bus.we && bus.w_addr != 5'd0) begin
            m_mem[bus.w_addr] <= bus.w_data;
            m_count <= m_count + 16'h1;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we && bus.w_addr == a) return bus.w_data;
`endif
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ra",  bus.ra_data,  model_read(bus.ra_addr));
            check("cmp_rb",  bus.rb_data,  model_read(bus.rb_addr));
            check("cmp_dbg", bus.dbg_data, model_read(bus.dbg_addr));
            check("cmp_cnt", {16'h0, bus.wr_count}, {16'h0, m_count});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_fwd;
        n_checks     = 0;
        n_pass       = 0;
        cmp_en       = 1'b0;
        rst_n        = 1'b0;
        bus.we       = 1'b0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        bus.ra_addr  = '0;
        bus.rb_addr  = '0;
        bus.dbg_addr = '0;

        // Reset held: every address reads 0 on all ports.
        for (int i = 0; i < 32; i++) begin
            bus.ra_addr  = 5'(i);
            bus.rb_addr  = 5'(31 - i);
            bus.dbg_addr = 5'(i);
            #1;
            check("rst_ra",  bus.ra_data,  32'h0);
            check("rst_rb",  bus.rb_data,  32'h0);
            check("rst_dbg", bus.dbg_data, 32'h0);
        end
        check("rst_cnt", {16'h0, bus.wr_count}, 32'h0);

        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Write r5, read on both ports next cycle.
        bus.we = 1'b1; bus.w_addr = 5'd5; bus.w_data = 32'hDEADBEEF;
        step();
        bus.we = 1'b0; bus.ra_addr = 5'd5; bus.rb_addr = 5'd5;
        #1;
        check("r5_ra", bus.ra_data, 32'hDEADBEEF);
        check("r5_rb", bus.rb_data, 32'hDEADBEEF);
        check("r5_cnt", {16'h0, bus.wr_count}, 32'h1);
        check("model_r5", model_read(5'd5), 32'hDEADBEEF);

        // Write to r0 is discarded and not counted.
        bus.we = 1'b1; bus.w_addr = 5'd0; bus.w_data = 32'h12345678;
        step();
        bus.we = 1'b0; bus.ra_addr = 5'd0;
        #1;
        check("r0_ra", bus.ra_data, 32'h0);
        check("r0_cnt", {16'h0, bus.wr_count}, 32'h1);
        check("model_cnt", {16'h0, m_count}, 32'h1);

        // Same-cycle read of the register being written.
        bus.we = 1'b1; bus.w_addr = 5'd7; bus.w_data = 32'h1;
        step();
        bus.w_data = 32'h2; bus.ra_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 32'h2;
`else
        exp_fwd = 32'h1;
`endif
        check("r7_pre", bus.ra_data, exp_fwd);
        step();
        bus.we = 1'b0;
        #1;
        check("r7_post", bus.ra_data, 32'h2);

        // Fill r1..r31, then pulse reset between edges.
        for (int i = 1; i < 32; i++) begin
            bus.we = 1'b1; bus.w_addr = 5'(i); bus.w_data = 32'h100 + i;
            step();
        end
        bus.we = 1'b0; bus.ra_addr = 5'd9; bus.rb_addr = 5'd31; bus.dbg_addr = 5'd1;
        #1;
        check("fill_r9",  bus.ra_data,  32'h109);
        check("fill_r31", bus.rb_data,  32'h11F);
        check("fill_r1",  bus.dbg_data, 32'h101);
        rst_n = 1'b0;
        #1;
        check("pulse_ra",  bus.ra_data,  32'h0);
        check("pulse_rb",  bus.rb_data,  32'h0);
        check("pulse_dbg", bus.dbg_data, 32'h0);
        check("pulse_cnt", {16'h0, bus.wr_count}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_r9", bus.ra_data, 32'h0);
        step();
        check("later_r9", bus.ra_data, 32'h0);

        // Reset asserted together with a write: reset wins.
        rst_n = 1'b0; bus.we = 1'b1; bus.w_addr = 5'd9; bus.w_data = 32'hAAAA5555;
        #1;
        check("rstw_ra", bus.ra_data, 32'h0);
        step();
        rst_n = 1'b1; bus.we = 1'b0;
        #1;
        check("rstw_r9", bus.ra_data, 32'h0);
        check("rstw_cnt", {16'h0, bus.wr_count}, 32'h0);
        bus.we = 1'b1; bus.w_data = 32'h55;
        step();
        bus.we = 1'b0;
        #1;
        check("rewrite_r9", bus.ra_data, 32'h55);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 800; n++) begin
            rst_n        = ($urandom_range(0, 39) != 0);
            bus.we       = $urandom_range(0, 3) != 0;
            bus.w_addr   = rand_addr();
            bus.w_data   = $urandom;
            bus.ra_addr  = ($urandom_range(0, 3) == 0) ? bus.w_addr : rand_addr();
            bus.rb_addr  = ($urandom_range(0, 3) == 0) ? bus.ra_addr : rand_addr();
            bus.dbg_addr = ($urandom_range(0, 3) == 0) ? bus.w_addr : rand_addr();
            step();
        end
        rst_n = 1'b1;

        // Counter wrap: 65537 writes to r1 from a cleared counter.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.we = 1'b1; bus.w_addr = 5'd1; bus.ra_addr = 5'd1;
        for (int i = 0; i < 65537; i++) begin
            bus.w_data = i;
            step();
        end
        bus.we = 1'b0;
        #1;
        check("wrap_cnt", {16'h0, bus.wr_count}, 32'h1);
        check("wrap_r1", bus.ra_data, 32'h10000);
        step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
